// File: rtl/background_fetch_sequencer.sv
// Background tile fetch sequencer: issues the four VRAM reads of each
// 8-dot tile slot, latches the returned bytes, and drives the pixel
// generator load/shift controls plus the loopy-v scroll update pulses.
module background_fetch_sequencer #(
  parameter int PRERENDER_LINE    = 261,
  parameter int LAST_VISIBLE_LINE = 239
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clock_EN,
  input  logic        rendering_EN,
  input  logic [8:0]  dot,
  input  logic [8:0]  scanline,
  input  logic [14:0] vAddr,
  input  logic        bgTableSel,
  input  logic [7:0]  vramData,
  output logic [13:0] vramAddr,
  output logic        vramRead,
  output logic        shiftEnable,
  output logic        loadIn,
  output logic [1:0]  tileAttr,
  output logic [7:0]  tileHighByte,
  output logic [7:0]  tileLowByte,
  output logic        incHoriz,
  output logic        incVert,
  output logic        copyHoriz,
  output logic        copyVert
);

  localparam logic [8:0] PRE_L  = 9'(PRERENDER_LINE);
  localparam logic [8:0] LAST_L = 9'(LAST_VISIBLE_LINE);

  // internal latches
  logic [7:0]  nt_byte_q, nt_byte_d;
  logic [7:0]  at_byte_q, at_byte_d;
  logic [1:0]  attr_sh_q, attr_sh_d;   // {v[6], v[1]} captured with the AT byte
  logic [7:0]  lo_latch_q, lo_latch_d;

  // registered outputs
  logic [13:0] vram_addr_q, vram_addr_d;
  logic        vram_read_q, vram_read_d;
  logic        shift_en_q, shift_en_d;
  logic        load_q, load_d;
  logic [1:0]  tile_attr_q, tile_attr_d;
  logic [7:0]  tile_hi_q, tile_hi_d;
  logic [7:0]  tile_lo_q, tile_lo_d;
  logic        inc_horiz_q, inc_horiz_d;
  logic        inc_vert_q, inc_vert_d;
  logic        copy_horiz_q, copy_horiz_d;
  logic        copy_vert_q, copy_vert_d;

  logic        active;
  logic        fetch_win;
  logic [2:0]  phase;
  logic [13:0] nt_addr, at_addr, pt_lo_addr, pt_hi_addr;
  logic [7:0]  attr_shifted;

  // Dot decode and fetch address formation
  always_comb begin
    active     = rendering_EN && ((scanline <= LAST_L) || (scanline == PRE_L));
    fetch_win  = ((dot >= 9'd1) && (dot <= 9'd256)) || ((dot >= 9'd321) && (dot <= 9'd336));
    phase      = dot[2:0] - 3'd1;
    nt_addr    = {2'b10, vAddr[11:0]};
    at_addr    = {2'b10, vAddr[11:10], 4'b1111, vAddr[9:7], vAddr[4:2]};
    // pattern fetch address; high plane sits 8 bytes above the low plane
    pt_lo_addr = {1'b0, bgTableSel, nt_byte_q, 1'b0, vAddr[14:12]};
    pt_hi_addr = {1'b0, bgTableSel, nt_byte_q, 1'b1, vAddr[14:12]};
    attr_shifted = at_byte_q >> {attr_sh_q, 1'b0};
  end

  // Per-dot next-state: pulses default low, latches default hold
  always_comb begin
    nt_byte_d    = nt_byte_q;
    at_byte_d    = at_byte_q;
    attr_sh_d    = attr_sh_q;
    lo_latch_d   = lo_latch_q;
    vram_addr_d  = vram_addr_q;
    vram_read_d  = 1'b0;
    shift_en_d   = 1'b0;
    load_d       = 1'b0;
    tile_hi_d    = tile_hi_q;
    tile_lo_d    = tile_lo_q;
    inc_horiz_d  = 1'b0;
    inc_vert_d   = 1'b0;
    copy_horiz_d = 1'b0;
    copy_vert_d  = 1'b0;
    // attribute follows the tile load by one enabled cycle to line up
    // with the pixel generator's delayed load
    tile_attr_d  = load_q ? attr_shifted[1:0] : tile_attr_q;

    if (active) begin
      shift_en_d   = ((dot >= 9'd2) && (dot <= 9'd257)) || ((dot >= 9'd322) && (dot <= 9'd337));
      inc_vert_d   = (dot == 9'd256);
      copy_horiz_d = (dot == 9'd257);
      copy_vert_d  = (scanline == PRE_L) && (dot >= 9'd280) && (dot <= 9'd304);
      if (fetch_win) begin
        case (phase)
          3'd0: begin vram_addr_d = nt_addr;    vram_read_d = 1'b1; end
          3'd1: nt_byte_d = vramData;
          3'd2: begin vram_addr_d = at_addr;    vram_read_d = 1'b1; end
          3'd3: begin at_byte_d = vramData; attr_sh_d = {vAddr[6], vAddr[1]}; end
          3'd4: begin vram_addr_d = pt_lo_addr; vram_read_d = 1'b1; end
          3'd5: lo_latch_d = vramData;
          3'd6: begin vram_addr_d = pt_hi_addr; vram_read_d = 1'b1; end
          default: begin
            tile_lo_d   = lo_latch_q;
            tile_hi_d   = vramData;
            load_d      = 1'b1;
            inc_horiz_d = 1'b1;
          end
        endcase
      end else if ((dot == 9'd337) || (dot == 9'd339)) begin
        // dummy nametable reads; the data is never used
        vram_addr_d = nt_addr;
        vram_read_d = 1'b1;
      end
    end
  end

  // State register: sync reset, otherwise advance only on dot enable
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      nt_byte_q    <= '0;
      at_byte_q    <= '0;
      attr_sh_q    <= '0;
      lo_latch_q   <= '0;
      vram_addr_q  <= '0;
      vram_read_q  <= 1'b0;
      shift_en_q   <= 1'b0;
      load_q       <= 1'b0;
      tile_attr_q  <= '0;
      tile_hi_q    <= '0;
      tile_lo_q    <= '0;
      inc_horiz_q  <= 1'b0;
      inc_vert_q   <= 1'b0;
      copy_horiz_q <= 1'b0;
      copy_vert_q  <= 1'b0;
    end else if (clock_EN) begin
      nt_byte_q    <= nt_byte_d;
      at_byte_q    <= at_byte_d;
      attr_sh_q    <= attr_sh_d;
      lo_latch_q   <= lo_latch_d;
      vram_addr_q  <= vram_addr_d;
      vram_read_q  <= vram_read_d;
      shift_en_q   <= shift_en_d;
      load_q       <= load_d;
      tile_attr_q  <= tile_attr_d;
      tile_hi_q    <= tile_hi_d;
      tile_lo_q    <= tile_lo_d;
      inc_horiz_q  <= inc_horiz_d;
      inc_vert_q   <= inc_vert_d;
      copy_horiz_q <= copy_horiz_d;
      copy_vert_q  <= copy_vert_d;
    end
  end

  assign vramAddr     = vram_addr_q;
  assign vramRead     = vram_read_q;
  assign shiftEnable  = shift_en_q;
  assign loadIn       = load_q;
  assign tileAttr     = tile_attr_q;
  assign tileHighByte = tile_hi_q;
  assign tileLowByte  = tile_lo_q;
  assign incHoriz     = inc_horiz_q;
  assign incVert      = inc_vert_q;
  assign copyHoriz    = copy_horiz_q;
  assign copyVert     = copy_vert_q;

endmodule

// File: tb/tb_background_fetch_sequencer.sv
// Bench for background_fetch_sequencer: directed tile-slot table, hand
// sequences for reset/line events/gating, and random lines checked
// against a tile-level reference model.
module tb_background_fetch_sequencer;

  localparam int PRE  = 261;
  localparam int LAST = 239;

  logic        clock = 1'b0;
  logic        reset_n, clock_EN, rendering_EN, bgTableSel;
  logic [8:0]  dot, scanline;
  logic [14:0] vAddr;
  logic [7:0]  vramData;
  logic [13:0] vramAddr;
  logic        vramRead, shiftEnable, loadIn, incHoriz, incVert, copyHoriz, copyVert;
  logic [1:0]  tileAttr;
  logic [7:0]  tileHighByte, tileLowByte;

  logic [7:0] vmem [16384];
  assign vramData = vmem[vramAddr];

  background_fetch_sequencer #(.PRERENDER_LINE(PRE), .LAST_VISIBLE_LINE(LAST)) dut (
    .clock(clock), .reset_n(reset_n), .clock_EN(clock_EN), .rendering_EN(rendering_EN),
    .dot(dot), .scanline(scanline), .vAddr(vAddr), .bgTableSel(bgTableSel),
    .vramData(vramData), .vramAddr(vramAddr), .vramRead(vramRead),
    .shiftEnable(shiftEnable), .loadIn(loadIn), .tileAttr(tileAttr),
    .tileHighByte(tileHighByte), .tileLowByte(tileLowByte), .incHoriz(incHoriz),
    .incVert(incVert), .copyHoriz(copyHoriz), .copyVert(copyVert));

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        e_read, e_shift, e_load, e_ih, e_iv, e_ch, e_cv, prev_load;
  logic [13:0] e_addr;
  logic [1:0]  e_attr, pend_attr;
  logic [7:0]  e_lo, e_hi;

  // line statistics
  int st_iv_n, st_iv_dot, st_ch_n, st_ch_dot, st_cv_n, st_cv_first, st_cv_last;
  int st_dummy_read, st_dummy_load, st_act;

  typedef struct {
    logic [14:0] v;
    logic        sel;
    logic [7:0]  nt, at, lo, hi;
    logic [13:0] nt_addr, at_addr, pt_addr;
    logic [1:0]  attr;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dot=%0d line=%0d got=%h exp=%h", name, dot, scanline, got, exp);
    end
  endtask

  function automatic logic [13:0] nt_a(input logic [14:0] v);
    return 14'h2000 | {2'd0, v[11:0]};
  endfunction

  function automatic logic [13:0] at_a(input logic [14:0] v);
    return 14'h23C0 | ({12'd0, v[11:10]} << 10) | ({11'd0, v[9:7]} << 3) | {11'd0, v[4:2]};
  endfunction

  task automatic model_reset();
    e_read = 0; e_shift = 0; e_load = 0; e_ih = 0; e_iv = 0; e_ch = 0; e_cv = 0;
    prev_load = 0; e_addr = '0; e_attr = '0; pend_attr = '0; e_lo = '0; e_hi = '0;
  endtask

  // Expected outputs after an enabled edge, computed straight from the
  // tile/dot rules and the VRAM contents.
  task automatic model_update();
    int d, s, ph, sh;
    bit act, fetch;
    logic [13:0] na, aa, pa;
    d = int'(dot); s = int'(scanline);
    act   = rendering_EN && (s <= LAST || s == PRE);
    fetch = (d >= 1 && d <= 256) || (d >= 321 && d <= 336);
    ph    = (d + 7) % 8;
    na = nt_a(vAddr);
    aa = at_a(vAddr);
    pa = ({13'd0, bgTableSel} << 12) | ({6'd0, vmem[na]} << 4) | {11'd0, vAddr[14:12]};
    sh = 4 * int'(vAddr[6]) + 2 * int'(vAddr[1]);
    if (prev_load) e_attr = pend_attr;
    e_read  = 0; e_load = 0; e_ih = 0;
    e_shift = act && ((d >= 2 && d <= 257) || (d >= 322 && d <= 337));
    e_iv    = act && d == 256;
    e_ch    = act && d == 257;
    e_cv    = act && s == PRE && d >= 280 && d <= 304;
    if (act && fetch) begin
      case (ph)
        0: begin e_read = 1; e_addr = na; end
        2: begin e_read = 1; e_addr = aa; end
        4: begin e_read = 1; e_addr = pa; end
        6: begin e_read = 1; e_addr = pa + 14'd8; end
        7: begin
          e_load = 1; e_ih = 1;
          e_lo = vmem[pa]; e_hi = vmem[pa + 14'd8];
          pend_attr = 2'((vmem[aa] >> sh) & 8'h3);
        end
        default: ;
      endcase
    end else if (act && (d == 337 || d == 339)) begin
      e_read = 1; e_addr = na;
    end
    prev_load = e_load;
  endtask

  task automatic compare_all();
    logic [38:0] got, exp;
    got = {vramRead, (e_read ? vramAddr : 14'h0), shiftEnable, loadIn, tileAttr,
           tileHighByte, tileLowByte, incHoriz, incVert, copyHoriz, copyVert};
    exp = {e_read, (e_read ? e_addr : 14'h0), e_shift, e_load, e_attr,
           e_hi, e_lo, e_ih, e_iv, e_ch, e_cv};
    chk("outputs", 64'(got), 64'(exp));
  endtask

  // one clock; inputs were set beforehand and are sampled 1ns after the edge
  task automatic tick(input logic en);
    clock_EN = en;
    @(posedge clock);
    #1;
    if (!reset_n) model_reset();
    else if (en) model_update();
    compare_all();
  endtask

  // drive dots d0..d1 of one line; mode 0 = always enabled,
  // 1 = enable every other cycle, 2 = random enable gaps
  task automatic run_range(input int s, input int d0, input int d1, input logic ren,
                           input int mode, input bit randv);
    scanline = 9'(s); rendering_EN = ren;
    st_iv_n = 0; st_iv_dot = -1; st_ch_n = 0; st_ch_dot = -1;
    st_cv_n = 0; st_cv_first = -1; st_cv_last = -1;
    st_dummy_read = 0; st_dummy_load = 0; st_act = 0;
    for (int d = d0; d <= d1; d++) begin
      dot = 9'(d);
      if (randv && (d < 1 || (d > 256 && d < 321) || d > 336 || ((d - 1) % 8 == 0))) begin
        vAddr = 15'($urandom); bgTableSel = 1'($urandom);
      end
      if (mode == 2) for (int k = 0; k < 3 && $urandom_range(0, 3) == 0; k++) tick(1'b0);
      tick(1'b1);
      if (incVert)   begin st_iv_n++; st_iv_dot = d; end
      if (copyHoriz) begin st_ch_n++; st_ch_dot = d; end
      if (copyVert)  begin st_cv_n++; if (st_cv_first < 0) st_cv_first = d; st_cv_last = d; end
      if (d == 337 || d == 339) begin
        st_dummy_read += int'(vramRead);
        st_dummy_load += int'(loadIn);
      end
      st_act += int'(vramRead) + int'(shiftEnable) + int'(loadIn) + int'(incHoriz)
              + int'(incVert) + int'(copyHoriz) + int'(copyVert);
      if (mode == 1) tick(1'b0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{v:15'h0000, sel:1'b1, nt:8'h24, at:8'hE4, lo:8'hAA, hi:8'h55,
               nt_addr:14'h2000, at_addr:14'h23C0, pt_addr:14'h1240, attr:2'd0};
    tbl[1] = '{v:15'h0042, sel:1'b0, nt:8'h5A, at:8'hE4, lo:8'h3C, hi:8'hC3,
               nt_addr:14'h2042, at_addr:14'h23C0, pt_addr:14'h05A0, attr:2'd3};
    tbl[2] = '{v:15'h0002, sel:1'b1, nt:8'h01, at:8'hE4, lo:8'h11, hi:8'h22,
               nt_addr:14'h2002, at_addr:14'h23C0, pt_addr:14'h1010, attr:2'd1};
    tbl[3] = '{v:15'h5A6D, sel:1'b0, nt:8'hFF, at:8'hB4, lo:8'h81, hi:8'h7E,
               nt_addr:14'h2A6D, at_addr:14'h2BE3, pt_addr:14'h0FF5, attr:2'd3};

    for (int a = 0; a < 16384; a++) vmem[a] = 8'($urandom);
    reset_n = 0; clock_EN = 0; rendering_EN = 0; dot = '0; scanline = '0;
    vAddr = '0; bgTableSel = 0;
    model_reset();
    tick(1'b1);
    tick(1'b1);
    reset_n = 1;

    // directed tile slots on visible line 0
    scanline = 9'd0; rendering_EN = 1; dot = 9'd0;
    tick(1'b1);
    for (int i = 0; i < 4; i++) begin
      vmem[tbl[i].nt_addr] = tbl[i].nt;
      vmem[tbl[i].at_addr] = tbl[i].at;
      vmem[tbl[i].pt_addr] = tbl[i].lo;
      vmem[tbl[i].pt_addr + 14'd8] = tbl[i].hi;
      vAddr = tbl[i].v; bgTableSel = tbl[i].sel;
      for (int ph = 0; ph < 8; ph++) begin
        dot = 9'(8 * i + ph + 1);
        tick(1'b1);
        case (ph)
          0: begin
            chk("nt_fetch", {vramRead, vramAddr}, {1'b1, tbl[i].nt_addr});
            if (i > 0) chk("tile_attr", 64'(tileAttr), 64'(tbl[i-1].attr));
          end
          2: chk("at_fetch", {vramRead, vramAddr}, {1'b1, tbl[i].at_addr});
          4: chk("pt_lo_fetch", {vramRead, vramAddr}, {1'b1, tbl[i].pt_addr});
          6: chk("pt_hi_fetch", {vramRead, vramAddr}, {1'b1, tbl[i].pt_addr + 14'd8});
          7: chk("tile_load", {loadIn, incHoriz, tileLowByte, tileHighByte},
                 {2'b11, tbl[i].lo, tbl[i].hi});
          default: chk("no_read_odd_phase", 64'(vramRead), 64'd0);
        endcase
      end
    end
    dot = 9'd33;
    tick(1'b1);
    chk("tile_attr_last", 64'(tileAttr), 64'(tbl[3].attr));

    // reset in the middle of a line, release on dot 1
    vAddr = 15'h0123; bgTableSel = 0;
    run_range(20, 0, 100, 1'b1, 0, 1'b0);
    reset_n = 0;
    dot = 9'd101; tick(1'b1);
    dot = 9'd102; tick(1'b1);
    chk("reset_outputs", {vramAddr, vramRead, shiftEnable, loadIn, tileAttr, tileHighByte,
        tileLowByte, incHoriz, incVert, copyHoriz, copyVert}, 64'd0);
    reset_n = 1;
    dot = 9'd1; tick(1'b1);
    chk("first_read_after_reset", {vramRead, vramAddr}, {1'b1, 14'h2123});
    run_range(20, 2, 340, 1'b1, 0, 1'b0);

    // visible-line events
    run_range(10, 0, 340, 1'b1, 0, 1'b1);
    chk("incvert_count", 64'(st_iv_n), 64'd1);
    chk("incvert_dot", 64'(st_iv_dot), 64'd256);
    chk("copyhoriz_count", 64'(st_ch_n), 64'd1);
    chk("copyhoriz_dot", 64'(st_ch_dot), 64'd257);
    chk("dummy_reads", 64'(st_dummy_read), 64'd2);
    chk("dummy_no_load", 64'(st_dummy_load), 64'd0);

    // pre-render line at half rate
    run_range(PRE, 0, 340, 1'b1, 1, 1'b1);
    chk("copyvert_cycles", 64'(st_cv_n), 64'd25);
    chk("copyvert_first", 64'(st_cv_first), 64'd280);
    chk("copyvert_last", 64'(st_cv_last), 64'd304);

    // idle line with rendering on
    run_range(240, 0, 340, 1'b1, 2, 1'b1);
    chk("idle_line_activity", 64'(st_act), 64'd0);

    // rendering drops for one dot mid-slot
    vAddr = 15'h1C45; bgTableSel = 1;
    run_range(5, 0, 99, 1'b1, 0, 1'b0);
    rendering_EN = 0; dot = 9'd100;
    tick(1'b1);
    chk("render_off_hold", {vramRead, shiftEnable, tileHighByte, tileLowByte},
        {2'b00, e_hi, e_lo});
    rendering_EN = 1; dot = 9'd101;
    tick(1'b1);
    chk("render_resume_read", 64'(vramRead), 64'd1);
    run_range(5, 102, 340, 1'b1, 0, 1'b0);

    // random lines with random enable gaps and scroll values
    for (int n = 0; n < 12; n++) begin
      run_range(int'($urandom_range(0, 261)), 0, 340, 1'($urandom_range(0, 3) != 0), 2, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
